// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers bit and group propagate/generate; stage 2 resolves carries and the sum.
module cla_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / BLOCK;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic             s1_c0;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;

  logic             s1_en;
  logic             s2_en;
  logic             accept;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0_in;
  logic [NG-1:0]    gp_in;
  logic [NG-1:0]    gg_in;
  logic             gp_acc;
  logic             gg_acc;

  logic [WIDTH:0]   c;
  logic             grp_carry;
  logic             bit_carry;
  logic [WIDTH-1:0] s2_sum;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = rst_n && s1_en;
  assign accept   = in_valid && in_ready;

  always_comb begin
    b_eff  = sub ? ~b : b;
    c0_in  = sub | cin;
    p_in   = a ^ b_eff;
    g_in   = a & b_eff;
    gp_in  = '0;
    gg_in  = '0;
    gp_acc = 1'b1;
    gg_acc = 1'b0;
    for (int j = 0; j < NG; j++) begin
      gp_acc = 1'b1;
      gg_acc = 1'b0;
      for (int k = 0; k < BLOCK; k++) begin
        gg_acc = g_in[j*BLOCK+k] | (p_in[j*BLOCK+k] & gg_acc);
        gp_acc = gp_acc & p_in[j*BLOCK+k];
      end
      gp_in[j] = gp_acc;
      gg_in[j] = gg_acc;
    end
  end

  // Group carries come only from registered GP/GG; bit carries never ripple across a group edge.
  always_comb begin
    c         = '0;
    grp_carry = s1_c0;
    bit_carry = 1'b0;
    for (int j = 0; j < NG; j++) begin
      bit_carry = grp_carry;
      for (int k = 0; k < BLOCK; k++) begin
        c[j*BLOCK+k] = bit_carry;
        bit_carry    = s1_g[j*BLOCK+k] | (s1_p[j*BLOCK+k] & bit_carry);
      end
      grp_carry = s1_gg[j] | (s1_gp[j] & grp_carry);
    end
    c[WIDTH] = grp_carry;
    s2_sum   = s1_p ^ c[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_p      <= '0;
      s1_g      <= '0;
      s1_c0     <= 1'b0;
      s1_gp     <= '0;
      s1_gg     <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= accept;
        if (accept) begin
          s1_p  <= p_in;
          s1_g  <= g_in;
          s1_c0 <= c0_in;
          s1_gp <= gp_in;
          s1_gg <= gg_in;
        end
      end
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          sum  <= s2_sum;
          cout <= c[WIDTH];
          ovf  <= c[WIDTH] ^ c[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: scoreboard of expected results fed on accept, checked on emit,
// plus directed arithmetic, throughput, backpressure, mid-flight reset and random traffic.
module tb_cla_adder_pipe;

  localparam int W = 8;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  int n_acc = 0;
  int n_out = 0;
  int cyc = 0;
  logic done;
  logic [W+1:0] sb_q[$];
  logic [W+1:0] exp_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cla_adder_pipe #(.WIDTH(W), .BLOCK(B)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // {ovf, cout, sum} from plain integer arithmetic and the sign-rule definition of overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                         input logic ci, input logic su);
    logic [W-1:0] be;
    logic [W:0]   full;
    logic         o;
    be   = su ? ~bb : bb;
    full = {1'b0, aa} + {1'b0, be} + {{W{1'b0}}, (su | ci)};
    o    = (aa[W-1] == be[W-1]) && (full[W-1] != aa[W-1]);
    return {o, full};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_extra: unexpected beat {ovf,cout,sum}=%h, none required", {ovf, cout, sum});
      end else begin
        exp_v = sb_q.pop_front();
        if ({ovf, cout, sum} !== exp_v) begin
          errors++;
          $display("FAIL scoreboard: got {ovf,cout,sum}=%h required %h", {ovf, cout, sum}, exp_v);
        end
      end
    end
    if (rst_n && in_valid && in_ready) begin
      sb_q.push_back(model(a, b, cin, sub));
      n_acc++;
    end
  end

  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci, input logic su);
    int t;
    t = 0;
    a = aa; b = bb; cin = ci; sub = su; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d required 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (sum !== '0)         begin errors++; $display("FAIL reset_sum: got %h required 00", sum); end
    if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout: got %b required 0", cout); end
    if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %b required 0", ovf); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  task automatic test_directed();
    vec_t v[6];
    int t;
    v[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    v[1] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    v[2] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    v[3] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    v[4] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    v[5] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(v[i].va, v[i].vb, v[i].vcin, v[i].vsub);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL dir%0d_early_valid: got %b required 0", i, out_valid);
      end
      t = 0;
      while (!out_valid && t < 3) begin
        @(negedge clk);
        t++;
      end
      checks += 2;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL dir%0d_latency: out_valid=%b required 1", i, out_valid);
      end
      if ({sum, cout, ovf} !== {v[i].esum, v[i].ecout, v[i].eovf}) begin
        errors++;
        $display("FAIL dir%0d_value: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, v[i].esum, v[i].ecout, v[i].eovf);
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int c_start;
    out_ready = 1'b1;
    c_start = cyc;
    for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    checks++;
    if (cyc - c_start != 8) begin
      errors++; $display("FAIL back_to_back_rate: took %0d cycles required 8", cyc - c_start);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held_sum;
    logic         held_c, held_o;
    int t;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        held_sum = sum; held_c = cout; held_o = ovf;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks += 2;
          if (out_valid !== 1'b1 || {sum, cout, ovf} !== {held_sum, held_c, held_o}) begin
            errors++;
            $display("FAIL stall_hold%0d: got v=%b %h/%b/%b required v=1 %h/%b/%b",
                     k, out_valid, sum, cout, ovf, held_sum, held_c, held_o);
          end
          if (k == 2 && in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_in_ready: got %b required 0", in_ready);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (n_acc != n_out) begin
      errors++; $display("FAIL backpressure_count: emitted %0d required %0d", n_out, n_acc);
    end
  endtask

  task automatic test_reset_midflight();
    int bad;
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midflight_fill: out_valid=%b required 1", out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight_out_valid: got %b required 0", out_valid); end
    if (sum !== '0)         begin errors++; $display("FAIL midflight_sum: got %h required 00", sum); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    n_acc = 0; n_out = 0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midflight_stale: stale out_valid cycles=%0d required 0", bad); end
    @(posedge clk); #1;
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    drain();
    checks++;
    if (n_out != 1) begin errors++; $display("FAIL midflight_first_beat: emitted %0d required 1", n_out); end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    done = 1'b0;
    n_acc = 0; n_out = 0;
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          ra = W'($urandom);
          rb = W'($urandom);
          if ($urandom_range(7) == 0) ra = {W{1'b1}};
          if ($urandom_range(7) == 0) rb = '0;
          send(ra, rb, 1'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (n_acc != n_out || n_acc != 3000) begin
      errors++; $display("FAIL random_count: accepted %0d emitted %0d required 3000", n_acc, n_out);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
